// File: rtl/ppu_fetch_tracker.sv
// PPU fetch classifier: oversamples the PPU read strobe and address, sorts each read into
// NT/AT/PTL/PTH, predicts AT fetches and produces filtered A12-rise and scanline strobes.
module ppu_fetch_tracker #(
  parameter int SYNC_STAGES  = 2,
  parameter int A12_LOW_MIN  = 3,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        map_rst,
  input  logic        ppu_oe,
  input  logic [13:0] ppu_addr,
  output logic        fetch_stb,
  output logic [1:0]  fetch_kind,
  output logic        next_is_at,
  output logic        nt_x0,
  output logic        nt_y0,
  output logic        at_x0,
  output logic        at_y0,
  output logic        a12_rise,
  output logic        scanline_stb,
  output logic        in_frame,
  output logic        mispredict,
  output logic [7:0]  line_fetch_cnt
);

  localparam int LAST   = SYNC_STAGES - 1;
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_TIMEOUT);
  localparam logic [2:0]        A12_MIN   = 3'(A12_LOW_MIN);

  localparam logic [1:0] KIND_NT  = 2'd0;
  localparam logic [1:0] KIND_AT  = 2'd1;
  localparam logic [1:0] KIND_PTL = 2'd2;
  localparam logic [1:0] KIND_PTH = 2'd3;

  typedef enum logic [1:0] {
    ST_P,
    ST_N1,
    ST_N2
  } pred_state_t;

  pred_state_t state;
  pred_state_t state_nxt;

  logic [SYNC_STAGES-1:0] oe_sync;
  logic [13:0]            addr_sync [SYNC_STAGES];
  logic                   oe_last_d;

  logic              prev_nt;
  logic [1:0]        nt_run;
  logic [1:0]        nt_run_nxt;
  logic [2:0]        a12_cnt;
  logic [2:0]        a12_cnt_nxt;
  logic [3:0]        quiet_run;
  logic [3:0]        quiet_run_nxt;
  logic [IDLE_W-1:0] idle_cnt;

  logic       fetch_evt;
  logic       a13;
  logic       a12;
  logic       at_row;
  logic [1:0] kind_c;
  logic       is_nt;
  logic       nia_nxt;
  logic       nt_x0_nxt;
  logic       nt_y0_nxt;
  logic       rise_c;
  logic       scan_c;
  logic       timeout_c;

  // Two-flop (or deeper) synchroniser; the extra oe flop gives the 1->0 edge detect.
  always_ff @(posedge clk) begin
    if (map_rst) begin
      oe_sync   <= '1;
      oe_last_d <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) addr_sync[i] <= '0;
    end else begin
      oe_sync   <= {oe_sync[SYNC_STAGES-2:0], ppu_oe};
      oe_last_d <= oe_sync[LAST];
      addr_sync[0] <= ppu_addr;
      for (int i = 1; i < SYNC_STAGES; i++) addr_sync[i] <= addr_sync[i-1];
    end
  end

  always_comb begin
    fetch_evt = oe_last_d & ~oe_sync[LAST];
    a13       = addr_sync[LAST][13];
    a12       = addr_sync[LAST][12];
    at_row    = (addr_sync[LAST][9:6] == 4'hF);

    if (!a13)                kind_c = addr_sync[LAST][3] ? KIND_PTH : KIND_PTL;
    else if (at_row && prev_nt) kind_c = KIND_AT;
    else                     kind_c = KIND_NT;
    is_nt = (kind_c == KIND_NT);

    nt_run_nxt = is_nt ? ((nt_run == 2'd3) ? 2'd3 : nt_run + 2'd1) : 2'd0;

    state_nxt = ST_P;
    case (state)
      ST_P:    state_nxt = is_nt ? ST_N1 : ST_P;
      ST_N1:   state_nxt = a13 ? ST_N2 : ST_P;
      ST_N2:   state_nxt = a13 ? ST_N2 : ST_P;
      default: state_nxt = ST_P;
    endcase

    // N2 with exactly two NTs in a row is the end-of-line dummy pair.
    nia_nxt = (state_nxt == ST_N1) || ((state_nxt == ST_N2) && (nt_run_nxt == 2'd2));

    nt_x0_nxt = is_nt ? addr_sync[LAST][0] : nt_x0;
    nt_y0_nxt = is_nt ? addr_sync[LAST][5] : nt_y0;

    a12_cnt_nxt   = a12 ? 3'd0 : ((a12_cnt == 3'd7) ? 3'd7 : a12_cnt + 3'd1);
    rise_c        = a12 && (a12_cnt >= A12_MIN);
    quiet_run_nxt = (a13 || !a12) ? ((quiet_run == 4'd8) ? 4'd8 : quiet_run + 4'd1) : 4'd0;
    scan_c        = rise_c && (quiet_run >= 4'd8);

    timeout_c = !fetch_evt && (idle_cnt == IDLE_LAST);
  end

  // Classification, prediction FSM and all registered outputs; a fetch outranks a timeout.
  always_ff @(posedge clk) begin
    if (map_rst) begin
      state          <= ST_P;
      prev_nt        <= 1'b0;
      nt_run         <= 2'd0;
      a12_cnt        <= 3'd0;
      quiet_run      <= 4'd0;
      idle_cnt       <= '0;
      fetch_stb      <= 1'b0;
      fetch_kind     <= KIND_NT;
      next_is_at     <= 1'b0;
      nt_x0          <= 1'b0;
      nt_y0          <= 1'b0;
      at_x0          <= 1'b0;
      at_y0          <= 1'b0;
      a12_rise       <= 1'b0;
      scanline_stb   <= 1'b0;
      in_frame       <= 1'b0;
      mispredict     <= 1'b0;
      line_fetch_cnt <= 8'd0;
    end else begin
      fetch_stb    <= fetch_evt;
      a12_rise     <= fetch_evt & rise_c;
      scanline_stb <= fetch_evt & scan_c;

      if (fetch_evt) begin
        fetch_kind <= kind_c;
        prev_nt    <= is_nt;
        state      <= state_nxt;
        nt_run     <= nt_run_nxt;
        next_is_at <= nia_nxt;
        nt_x0      <= nt_x0_nxt;
        nt_y0      <= nt_y0_nxt;
        if (nia_nxt && !next_is_at) begin
          at_x0 <= nt_x0_nxt;
          at_y0 <= nt_y0_nxt;
        end
        if (next_is_at && (kind_c != KIND_AT)) mispredict <= 1'b1;
        a12_cnt   <= a12_cnt_nxt;
        quiet_run <= quiet_run_nxt;
        if (scan_c)                       line_fetch_cnt <= 8'd0;
        else if (line_fetch_cnt != 8'hFF) line_fetch_cnt <= line_fetch_cnt + 8'd1;
        idle_cnt <= '0;
        in_frame <= 1'b1;
      end else begin
        if (timeout_c) begin
          in_frame   <= 1'b0;
          state      <= ST_P;
          prev_nt    <= 1'b0;
          nt_run     <= 2'd0;
          next_is_at <= 1'b0;
          a12_cnt    <= 3'd0;
        end
        if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/ppu_fetch_tracker.md
# ppu_fetch_tracker

Synchronous PPU fetch classifier that sits directly upstream of the mapper-098 attribute-redirect and IRQ logic. It oversamples the asynchronous PPU read strobe and address in the system clock domain and classifies every PPU read as nametable (NT), attribute (AT), pattern-low (PTL) or pattern-high (PTH). It predicts whether the next fetch is an AT fetch, and latches the tile coordinate LSBs that the attribute redirect consumes. It also emits filtered A12-rise and scanline strobes, plus a frame-activity flag, so the mapper no longer clocks state on the PPU strobe edge.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser depth on ppu_oe and ppu_addr (min 2).
- A12_LOW_MIN, 3: consecutive A12=0 fetches required before an A12=1 fetch counts as a rise.
- IDLE_TIMEOUT, 1024: clk cycles without a fetch before in_frame clears.

Ports:
- clk  in  1  system clock, ≥ 4× PPU fetch rate (nominal 50 MHz); single clock domain.
- map_rst  in  1  synchronous, active-high reset.
- ppu_oe  in  1  PPU read strobe, active low, asynchronous to clk.
- ppu_addr  in  14  PPU address, asynchronous, stable while ppu_oe is low.
- fetch_stb  out  1  one-clk pulse per classified fetch.
- fetch_kind  out  2  valid with fetch_stb and held until the next strobe: 0 = NT, 1 = AT, 2 = PTL, 3 = PTH.
- next_is_at  out  1  prediction that the next fetch is AT.
- nt_x0, nt_y0  out  1 each  addr[0] and addr[5] of the most recent NT fetch.
- at_x0, at_y0  out  1 each  nt_x0/nt_y0 frozen at the moment next_is_at rises.
- a12_rise  out  1  one-clk pulse on a filtered A12 rising fetch.
- scanline_stb  out  1  one-clk pulse on the first a12_rise after ≥ 8 consecutive A13=1-or-A12=0 fetches.
- in_frame  out  1  set on any fetch; cleared after IDLE_TIMEOUT idle clks.
- mispredict  out  1  sticky; set when next_is_at was high but the next fetch did not classify AT.
- line_fetch_cnt  out  8  fetches since the last scanline_stb, saturating at 255.

## Operation
- Sync: ppu_oe and ppu_addr each pass through SYNC_STAGES flops. A fetch event is the synchronised ppu_oe 1→0 transition. The address is sampled from the final synchroniser stage on that same clk.
- Classification of each fetch, addr = sampled value:
  - A13=0: PTH if addr[3]=1, otherwise PTL.
  - A13=1: AT if addr[9:6]=4'hF and the previous fetch was NT; otherwise NT.
- Prediction FSM, states P (last fetch was pattern), N1 (one NT after a pattern), N2 (two or more consecutive A13=1 fetches):
  - P→N1 on an NT fetch; next_is_at=1 while in N1.
  - N1→N2 on an A13=1 fetch; N1→P on an A13=0 fetch.
  - N2 stays in N2 on an A13=1 fetch; N2→P on an A13=0 fetch.
  - next_is_at is also 1 in N2 when exactly two consecutive NT fetches have been seen. This covers the end-of-line dummy pair.
  - next_is_at is 0 in all other cases.
- On a rising edge of next_is_at, at_x0/at_y0 ← nt_x0/nt_y0. at_x0/at_y0 are otherwise held.
- A12 filter: a counter of consecutive A12=0 fetches saturates at 7. An A12=1 fetch with count ≥ A12_LOW_MIN pulses a12_rise. Any A12=1 fetch clears the counter.
- mispredict is cleared only by map_rst.
- line_fetch_cnt: cleared to 0 on scanline_stb, otherwise +1 per fetch_stb, saturating at 255.
- Idle counter: cleared on each fetch, otherwise increments. Reaching IDLE_TIMEOUT clears in_frame, resets the FSM to P, and clears the A12 counter.

## Timing
- Reset values: every output 0; FSM in P; all counters 0; synchronisers loaded with ppu_oe=1 and addr=0.
- Latency: fetch_stb, fetch_kind, a12_rise and scanline_stb are asserted SYNC_STAGES+1 clks after the physical ppu_oe fall.
- next_is_at, nt_* and at_* update on the same clk as fetch_stb. The consumer may use them on the following PPU fetch, which is ≥ 8 clks later at nominal clk.
- A fetch and an idle timeout on the same clk: the fetch wins, and in_frame stays 1.
- A ppu_oe low glitch shorter than 1 clk may be missed. This is acceptable. A strobe held low is a single fetch.
- map_rst mid-line: all state returns to reset values on the next clk. The first subsequent fetch is classified with "previous fetch" treated as pattern.

## Test plan
- Tile sequence NT 0x2041, AT 0x23C8, PTL 0x0120, PTH 0x0128 → fetch_kind 0,1,2,3; next_is_at=1 only after the NT; nt_x0=1, nt_y0=0; at_x0=1.
- Sprite-phase garbage NT 0x2000, NT 0x2000, PTL 0x1000 → second fetch is kind 0, mispredict=1, a12_rise pulses on the PTL.
- Four fetches with A12=0, then one with A12=1 → a12_rise pulses once. Immediately following A12=1 fetches → no further pulse. Two A12=0 fetches, then A12=1 → no pulse (A12_LOW_MIN=3).
- 300 fetches with no scanline → line_fetch_cnt=255 (saturated). Then 8 NT fetches and one A12 rise → scanline_stb pulses and the count resets to 0.
- No fetch for 1024 clks → in_frame=0 and FSM in P. A fetch arriving on clk 1024 → in_frame remains 1.
- map_rst asserted between NT and AT fetches → all outputs 0 next clk. The following 0x23C8 fetch classifies as NT.
